spike_synapse: RTL and testbench

SPIKE_SYNAPSE -- requirements
Module: spike_synapse

---
 rtl/spike_synapse_pkg.sv | 34 +++
 rtl/spike_synapse_fifo.sv | 59 +++++
 rtl/spike_synapse.sv | 124 ++++++++++++
 tb/tb_spike_synapse.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_synapse_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// spike_synapse_pkg: FSM states, Q2.16 constants, saturating add
// Rev 1.0
// ------------------------------------------------------------------
package spike_synapse_pkg;

  localparam int FX_W = 18;
  localparam logic signed [FX_W-1:0] FX_ONE = 18'sh1_0000;
  localparam logic signed [FX_W-1:0] FX_MAX = 18'sh1_FFFF;
  localparam logic signed [FX_W-1:0] FX_MIN = 18'sh2_0000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_ACCUM = 2'd2;

  // Returns {overflow, value}; value is clamped to a w-bit signed range.
  function automatic logic [32:0] sat_add(input logic signed [31:0] a,
                                          input logic signed [31:0] b,
                                          input int w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) return {1'b1, hi[31:0]};
    if (sum < lo) return {1'b1, lo[31:0]};
    return {1'b0, sum[31:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spike_synapse_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// spike_fifo: small synchronous FIFO holding presynaptic spike ids
// Rev 1.0
// ------------------------------------------------------------------
module spike_fifo #(
  parameter int N     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         pop,
  output logic [N-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/spike_synapse.sv
`default_nettype none
// ------------------------------------------------------------------
// spike_synapse: queued spike events accumulate weights into a decaying current
// Rev 1.0
// ------------------------------------------------------------------
module spike_synapse
  import spike_synapse_pkg::*;
#(
  parameter  int N         = 18,
  parameter  int NSYN      = 8,
  parameter  int DEPTH     = 4,
  parameter  int TAU_SHIFT = 3,
  localparam int IDW       = (NSYN > 1) ? $clog2(NSYN) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                apply,
  input  logic                spike_valid,
  input  logic [IDW-1:0]      spike_id,
  output logic                spike_ready,
  input  logic                w_we,
  input  logic [IDW-1:0]      w_addr,
  input  logic signed [N-1:0] w_data,
  output logic signed [N-1:0] i_syn,
  output logic                sat
);

  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [IDW-1:0]     fifo_id;
  logic [IDW-1:0]     cur_id;
  logic signed [N-1:0] weight [NSYN];
  logic signed [N-1:0] w_reg;
  logic signed [N-1:0] decayed;
  logic signed [31:0]  acc_val;
  logic                acc_ovf;
  logic                unused_acc_hi;
  state_t              state;

  assign spike_ready = ~fifo_full;
  assign push        = spike_valid & ~fifo_full;
  assign decayed     = i_syn - (i_syn >>> TAU_SHIFT);
  assign {acc_ovf, acc_val} = sat_add(32'(i_syn), 32'(w_reg), N);
  assign unused_acc_hi = ^acc_val[31:N];

  // A pending decay stalls ACCUM, so no pop happens that cycle.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE:  pop = ~fifo_empty;
      ST_ACCUM: pop = ~apply & ~fifo_empty;
      default:  pop = 1'b0;
    endcase
  end

  spike_fifo #(
    .N     (IDW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (spike_id),
    .pop       (pop),
    .pop_data  (fifo_id),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NSYN; k++)
        weight[k] <= '0;
    end else if (w_we) begin
      weight[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cur_id <= '0;
      w_reg  <= '0;
      i_syn  <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_id <= fifo_id;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          w_reg <= weight[cur_id];
          state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (!apply) begin
            if (!fifo_empty) begin
              cur_id <= fifo_id;
              state  <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (apply) begin
        i_syn <= decayed;
      end else if (state == ST_ACCUM) begin
        i_syn <= acc_val[N-1:0];
        if (acc_ovf)
          sat <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_synapse.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_spike_synapse: scoreboard bench for spike_synapse
// Rev 1.0
// ------------------------------------------------------------------
module tb_spike_synapse;

  localparam int N      = 18;
  localparam int NSYN   = 8;
  localparam int IDW    = 3;
  localparam int FX_HI  = 131071;
  localparam int FX_LO  = -131072;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                apply;
  logic                spike_valid;
  logic [IDW-1:0]      spike_id;
  logic                spike_ready;
  logic                w_we;
  logic [IDW-1:0]      w_addr;
  logic signed [N-1:0] w_data;
  logic signed [N-1:0] i_syn;
  logic                sat;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_q[$];
  int  model_w[NSYN];
  int  model_isyn;
  bit  mon_en = 1'b0;
  bit  saw_full;
  logic signed [N-1:0] prev_isyn = '0;

  always #5 clk = ~clk;

  spike_synapse u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .apply       (apply),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_ready (spike_ready),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .i_syn       (i_syn),
    .sat         (sat)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int sat_m(input int a, input int b);
    int s;
    s = a + b;
    if (s > FX_HI) s = FX_HI;
    if (s < FX_LO) s = FX_LO;
    return s;
  endfunction

  function automatic int decay_m(input int a);
    return a - (a >>> 3);
  endfunction

  // Every change of i_syn consumes the next expected value in order.
  always @(negedge clk) begin
    if (mon_en && (i_syn !== prev_isyn)) begin
      if (exp_q.size() == 0) check_eq("unexpected_change", int'(i_syn), int'(prev_isyn));
      else check_eq("sb_isyn", int'(i_syn), exp_q.pop_front());
    end
    prev_isyn = i_syn;
  end

  task automatic do_reset();
    mon_en      = 1'b0;
    reset_n     = 1'b0;
    spike_valid = 1'b0;
    apply       = 1'b0;
    w_we        = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_isyn", int'(i_syn), 0);
    check_eq("rst_ready", int'(spike_ready), 1);
    check_eq("rst_sat", int'(sat), 0);
    reset_n = 1'b1;
    exp_q.delete();
    model_isyn = 0;
    foreach (model_w[k]) model_w[k] = 0;
    #1;
    prev_isyn = i_syn;
    mon_en    = 1'b1;
  endtask

  task automatic write_w(input int addr, input int val);
    @(negedge clk);
    w_we   = 1'b1;
    w_addr = IDW'(addr);
    w_data = N'(val);
    @(negedge clk);
    w_we = 1'b0;
    model_w[addr] = val;
  endtask

  task automatic send_spike(input int id, input bit push_exp);
    int waited;
    waited      = 0;
    spike_valid = 1'b1;
    spike_id    = IDW'(id);
    while (!spike_ready && waited < 200) begin
      saw_full = 1'b1;
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check_eq("accept_timeout", waited, 0);
    @(posedge clk);
    if (push_exp) begin
      model_isyn = sat_m(model_isyn, model_w[id]);
      exp_q.push_back(model_isyn);
    end
    @(negedge clk);
    spike_valid = 1'b0;
  endtask

  task automatic apply_pulse();
    @(negedge clk);
    apply      = 1'b1;
    model_isyn = decay_m(model_isyn);
    exp_q.push_back(model_isyn);
    @(negedge clk);
    apply = 1'b0;
  endtask

  task automatic drain();
    repeat (30) @(negedge clk);
    while (exp_q.size() > 0) check_eq("drain", int'(i_syn), exp_q.pop_front());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int old;
    int ids[6];
    ids = '{4, 5, 6, 7, 4, 5};
    reset_n = 1'b0; apply = 1'b0; spike_valid = 1'b0; spike_id = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; saw_full = 1'b0;

    // Single event latency
    do_reset();
    write_w(2, 'h2666);
    send_spike(2, 1'b1);
    n = 0;
    old = int'(i_syn);
    while (n < 10) begin
      @(posedge clk); #1; n++;
      if (int'(i_syn) != old) break;
    end
    check_eq("latency_edges", n, 3);
    drain();

    // Back-to-back events then one decay
    do_reset();
    write_w(2, 'h2666);
    send_spike(2, 1'b1);
    send_spike(2, 1'b1);
    drain();
    check_eq("two_spikes", int'(i_syn), 'h4CCC);
    apply_pulse();
    drain();
    check_eq("decay", int'(i_syn), 'h4333);

    // Weight write coinciding with FETCH of the same entry reads the old weight
    write_w(5, 'h0100);
    send_spike(5, 1'b1);
    @(negedge clk);
    w_we = 1'b1; w_addr = 3'd5; w_data = 18'sh0_7000;
    @(negedge clk);
    w_we = 1'b0;
    model_w[5] = 'h7000;
    drain();
    send_spike(5, 1'b1);
    drain();
    check_eq("write_new", int'(i_syn), 'hB433);

    // Saturation both ways
    do_reset();
    write_w(0, 'h10000);
    repeat (3) send_spike(0, 1'b1);
    drain();
    check_eq("sat_pos", int'(i_syn), FX_HI);
    check_eq("sat_flag", int'(sat), 1);
    write_w(1, FX_LO);
    repeat (6) send_spike(1, 1'b1);
    drain();
    check_eq("sat_neg", int'(i_syn), FX_LO);

    // Reset with events queued and one in flight
    mon_en = 1'b0;
    repeat (4) send_spike(0, 1'b0);
    do_reset();
    repeat (20) @(negedge clk);
    check_eq("post_reset_quiet", int'(i_syn), 0);
    send_spike(0, 1'b1);
    drain();
    check_eq("weights_cleared", int'(i_syn), 0);

    // FIFO fills while the FSM is held by apply, then drains in order
    do_reset();
    write_w(4, 'h0100);
    write_w(5, 'h1000);
    write_w(6, 'h0010);
    write_w(7, 'h0001);
    saw_full = 1'b0;
    apply = 1'b1;
    fork
      begin
        foreach (ids[k]) send_spike(ids[k], 1'b1);
      end
      begin
        repeat (12) @(negedge clk);
        apply = 1'b0;
      end
    join
    drain();
    check_eq("ready_low_seen", int'(saw_full), 1);
    check_eq("order_final", int'(i_syn), 'h2211);

    // Decay in the ACCUM cycle takes priority, accumulation follows
    do_reset();
    write_w(3, 'h4000);
    send_spike(3, 1'b1);
    drain();
    check_eq("pre_apply", int'(i_syn), 'h4000);
    write_w(3, 'h1000);
    send_spike(3, 1'b0);
    exp_q.push_back('h3800);
    exp_q.push_back('h4800);
    model_isyn = 'h4800;
    @(negedge clk);
    @(negedge clk);
    apply = 1'b1;
    @(negedge clk);
    check_eq("decay_in_accum", int'(i_syn), 'h3800);
    apply = 1'b0;
    @(negedge clk);
    check_eq("accum_after_decay", int'(i_syn), 'h4800);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
